// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared state encoding and defaults for the Counter controller.
package counter_ctrl_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;
   localparam int CTRL_TIMEOUT_DEFAULT = 1024;
endpackage

// File: rtl/counter_ctrl_wdog.sv
// counter_ctrl_wdog: saturating run-cycle counter with watchdog compare.
module counter_ctrl_wdog #(
   parameter int CYC_WIDTH = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 clr,
   input  logic                 en,
   output logic [CYC_WIDTH-1:0] count,
   output logic                 expired
);
   always_ff @(posedge clk or negedge reset_l)
      if (!reset_l) count <= '0;
      else if (clr) count <= '0;
      else if (en && count != '1) count <= count + CYC_WIDTH'(1);
   // expired marks the last RUN cycle in which done is still honoured
   assign expired = count >= CYC_WIDTH'(TIMEOUT - 1);
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: runs the Counter to a stop target, times it, returns one result per command.
// Define COUNTER_CTRL_TRACE_EN to print start/done trace messages in simulation.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int STOP_WIDTH = 8,
   parameter int CYC_WIDTH  = 16,
   parameter int TIMEOUT    = CTRL_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_l,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [STOP_WIDTH-1:0] cmd_stop,
   output logic [STOP_WIDTH-1:0] ctr_stop,
   output logic                  ctr_reset_l,
   input  logic                  ctr_done,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [CYC_WIDTH-1:0]  rsp_cycles,
   output logic                  rsp_timeout,
   output logic                  busy
);
   state_e               state;
   logic [CYC_WIDTH-1:0] count;
   logic                 expired;
   logic                 accept;

   assign cmd_ready = state == S_IDLE;
   assign rsp_valid = state == S_RESP;
   assign busy      = state != S_IDLE;
   assign accept    = cmd_ready && cmd_valid;

   counter_ctrl_wdog #(.CYC_WIDTH(CYC_WIDTH), .TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .reset_l (reset_l),
      .clr     (accept),
      .en      (state == S_RUN),
      .count   (count),
      .expired (expired)
   );

   // ctr_reset_l is a flop output so the Counter never sees a decode glitch
   always_ff @(posedge clk or negedge reset_l)
      if (!reset_l) begin
         state       <= S_IDLE;
         ctr_stop    <= '0;
         ctr_reset_l <= 1'b0;
         rsp_cycles  <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE:
               if (cmd_valid) begin
                  ctr_stop    <= cmd_stop;
                  ctr_reset_l <= 1'b1;
                  state       <= S_RUN;
`ifdef COUNTER_CTRL_TRACE_EN
                  $display("ctrl: start stop=%0d", cmd_stop);
`endif
               end
            S_RUN:
               if (ctr_done || expired) begin
                  rsp_cycles  <= ctr_done ? count : CYC_WIDTH'(TIMEOUT);
                  rsp_timeout <= !ctr_done;
                  ctr_reset_l <= 1'b0;
                  state       <= S_RESP;
`ifdef COUNTER_CTRL_TRACE_EN
                  $display("ctrl: done cycles=%0d timeout=%0d",
                           ctr_done ? count : CYC_WIDTH'(TIMEOUT), !ctr_done);
`endif
               end
            S_RESP: if (rsp_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
endmodule
